mem_access_ctrl: RTL and testbench

- Initiator side of the data-memory interface, placed between the MEM pipeline stage and the synchronous word-wide data RAM.
- Accepts one load/store request at a time and handles byte-lane selection, write-data replication and load sign/zero extension.
- Holds the pipeline through a programmable number of RAM wait cycles.
- Detects misaligned halfword/word accesses and suppresses the RAM access for them.

---
 rtl/mem_access_ctrl_pkg.sv | 38 +++
 rtl/mem_access_ctrl_align.sv | 74 +++++++
 rtl/mem_access_ctrl.sv | 130 +++++++++++++
 tb/tb_mem_access_ctrl.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_ctrl_pkg.sv
// Shared types for the data-memory initiator: op codes, FSM states and the
// latched request payload.
`timescale 1ns/1ps
package mem_access_ctrl_pkg;

    localparam int unsigned XLEN = 32;
    localparam int unsigned SELW = 4;

    typedef enum logic [2:0] {
        MEM_OP_LB  = 3'b000,
        MEM_OP_LBU = 3'b001,
        MEM_OP_LH  = 3'b010,
        MEM_OP_LHU = 3'b011,
        MEM_OP_LW  = 3'b100,
        MEM_OP_SB  = 3'b101,
        MEM_OP_SH  = 3'b110,
        MEM_OP_SW  = 3'b111
    } mem_op_e;

    typedef enum logic [1:0] {
        MEM_IDLE   = 2'd0,
        MEM_ACCESS = 2'd1,
        MEM_DONE   = 2'd2
    } mem_state_e;

    // Request captured at acceptance and replayed onto the RAM during ACCESS
    typedef struct packed {
        mem_op_e           op;
        logic [XLEN-1:0]   addr;
        logic [SELW-1:0]   sel;
        logic [XLEN-1:0]   data;
    } mem_req_t;

    function automatic logic is_store(input mem_op_e op);
        return (op == MEM_OP_SB) || (op == MEM_OP_SH) || (op == MEM_OP_SW);
    endfunction

endpackage

// File: rtl/mem_access_ctrl_align.sv
// Combinational lane logic for the data-memory initiator.
// Request side: op_i/addr_lo_i/wdata_i -> byte enables, replicated store
//   data, misalignment flag.
// Load side: ld_op_i/ld_addr_lo_i/ld_rdata_i -> right-aligned, extended
//   load result (0 for stores).
`timescale 1ns/1ps
module mem_align
    import mem_access_ctrl_pkg::*;
(
    input  logic [2:0]  op_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] wdata_i,
    output logic [3:0]  sel_o,
    output logic [31:0] wdata_rep_o,
    output logic        misalign_o,
    input  logic [2:0]  ld_op_i,
    input  logic [1:0]  ld_addr_lo_i,
    input  logic [31:0] ld_rdata_i,
    output logic [31:0] ld_data_o
);

    mem_op_e     req_op;
    mem_op_e     ld_op;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    assign req_op = mem_op_e'(op_i);
    assign ld_op  = mem_op_e'(ld_op_i);

    // Byte enables, store replication and alignment for the incoming request
    always_comb begin
        sel_o       = 4'b0000;
        wdata_rep_o = 32'h0000_0000;
        misalign_o  = 1'b0;
        case (req_op)
            MEM_OP_LB, MEM_OP_LBU, MEM_OP_SB: begin
                sel_o       = 4'b0001 << addr_lo_i;
                wdata_rep_o = {4{wdata_i[7:0]}};
            end
            MEM_OP_LH, MEM_OP_LHU, MEM_OP_SH: begin
                sel_o       = 4'b0011 << {addr_lo_i[1], 1'b0};
                wdata_rep_o = {2{wdata_i[15:0]}};
                misalign_o  = addr_lo_i[0];
            end
            default: begin
                sel_o       = 4'b1111;
                wdata_rep_o = wdata_i;
                misalign_o  = |addr_lo_i;
            end
        endcase
        // Loads drive no write data onto the bus
        if (!is_store(req_op)) begin
            wdata_rep_o = 32'h0000_0000;
        end
    end

    // Shift the addressed lane(s) down to bit 0
    assign ld_byte = 8'(ld_rdata_i >> {ld_addr_lo_i, 3'b000});
    assign ld_half = 16'(ld_rdata_i >> {ld_addr_lo_i[1], 4'b0000});

    // Sign/zero extension of the load result
    always_comb begin
        ld_data_o = 32'h0000_0000;
        case (ld_op)
            MEM_OP_LB:  ld_data_o = {{24{ld_byte[7]}}, ld_byte};
            MEM_OP_LBU: ld_data_o = {24'h00_0000, ld_byte};
            MEM_OP_LH:  ld_data_o = {{16{ld_half[15]}}, ld_half};
            MEM_OP_LHU: ld_data_o = {16'h0000, ld_half};
            MEM_OP_LW:  ld_data_o = ld_rdata_i;
            default:    ld_data_o = 32'h0000_0000;
        endcase
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// Initiator between the MEM pipeline stage and a synchronous word-wide RAM.
// One request at a time: IDLE accepts, ACCESS drives the RAM for
// WAIT_CYCLES+1 cycles, DONE pulses valid_o with the extended load result.
// Ports: clk/rst (async active-high); req_i/op_i/addr_i/wdata_i from MEM;
//   stall_o/valid_o/rdata_o/misalign_o back to the pipeline;
//   ram_ce_o/ram_we_o/ram_addr_o/ram_sel_o/ram_data_o/ram_data_i to RAM.
// stall_o and misalign_o react combinationally to req_i in IDLE; the RAM
// strobes decode the registered state so reset drops them at once.
`timescale 1ns/1ps
module mem_access_ctrl
    import mem_access_ctrl_pkg::*;
#(
    parameter int unsigned WAIT_CYCLES = 1,
    parameter int unsigned CNT_W       = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_i,
    input  logic [2:0]  op_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic        stall_o,
    output logic        valid_o,
    output logic [31:0] rdata_o,
    output logic        misalign_o,
    output logic        ram_ce_o,
    output logic        ram_we_o,
    output logic [31:0] ram_addr_o,
    output logic [3:0]  ram_sel_o,
    output logic [31:0] ram_data_o,
    input  logic [31:0] ram_data_i
);

    mem_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    mem_req_t         req_q, req_d;
    logic [31:0]      rdata_q, rdata_d;

    logic [3:0]       sel_c;
    logic [31:0]      wdata_rep_c;
    logic             misalign_c;
    logic [31:0]      ld_data_c;

    mem_align u_align (
        .op_i         (op_i),
        .addr_lo_i    (addr_i[1:0]),
        .wdata_i      (wdata_i),
        .sel_o        (sel_c),
        .wdata_rep_o  (wdata_rep_c),
        .misalign_o   (misalign_c),
        .ld_op_i      (req_q.op),
        .ld_addr_lo_i (req_q.addr[1:0]),
        .ld_rdata_i   (ram_data_i),
        .ld_data_o    (ld_data_c)
    );

    // State, counter and data registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= MEM_IDLE;
            cnt_q   <= '0;
            req_q   <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            rdata_q <= rdata_d;
        end
    end

    // Next-state and output decode
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        req_d      = req_q;
        rdata_d    = rdata_q;
        stall_o    = 1'b0;
        valid_o    = 1'b0;
        misalign_o = 1'b0;
        ram_ce_o   = 1'b0;
        ram_we_o   = 1'b0;
        ram_addr_o = 32'h0000_0000;
        ram_sel_o  = 4'b0000;
        ram_data_o = 32'h0000_0000;
        case (state_q)
            MEM_IDLE: begin
                if (req_i) begin
                    if (misalign_c) begin
                        misalign_o = 1'b1;
                    end else begin
                        stall_o    = 1'b1;
                        req_d.op   = mem_op_e'(op_i);
                        req_d.addr = addr_i;
                        req_d.sel  = sel_c;
                        req_d.data = wdata_rep_c;
                        cnt_d      = CNT_W'(WAIT_CYCLES);
                        state_d    = MEM_ACCESS;
                    end
                end
            end
            MEM_ACCESS: begin
                stall_o    = 1'b1;
                ram_ce_o   = 1'b1;
                ram_we_o   = is_store(req_q.op);
                ram_addr_o = {req_q.addr[31:2], 2'b00};
                ram_sel_o  = req_q.sel;
                ram_data_o = req_q.data;
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    // Stores yield 0 from the extension logic
                    rdata_d = ld_data_c;
                    state_d = MEM_DONE;
                end
            end
            MEM_DONE: begin
                // req_i still shows the finished request here; ignore it
                valid_o = 1'b1;
                state_d = MEM_IDLE;
            end
            default: begin
                state_d = MEM_IDLE;
            end
        endcase
    end

    assign rdata_o = rdata_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
`timescale 1ns/1ps
module tb_mem_access_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst1, rst3, req1, req3;
    logic [2:0]  op_i;
    logic [31:0] addr_i, wdata_i;

    logic        stall1, valid1, mis1, ce1, we1;
    logic [31:0] rdata1, addr1, data1, rin1;
    logic [3:0]  sel1;
    logic        stall3, valid3, mis3, ce3, we3;
    logic [31:0] rdata3, addr3, data3, rin3;
    logic [3:0]  sel3;

    logic [31:0] ram1 [0:1023];

    int n_pass  = 0;
    int n_total = 0;

    logic [15:0] stall_map, ce_map, we_map, valid_map, mis_map;
    logic [3:0]  seen_sel;
    logic [31:0] seen_addr, seen_data, res_rdata;

    mem_access_ctrl #(.WAIT_CYCLES(1), .CNT_W(4)) u_dut1 (
        .clk(clk), .rst(rst1), .req_i(req1), .op_i(op_i), .addr_i(addr_i),
        .wdata_i(wdata_i), .stall_o(stall1), .valid_o(valid1), .rdata_o(rdata1),
        .misalign_o(mis1), .ram_ce_o(ce1), .ram_we_o(we1), .ram_addr_o(addr1),
        .ram_sel_o(sel1), .ram_data_o(data1), .ram_data_i(rin1)
    );

    mem_access_ctrl #(.WAIT_CYCLES(3), .CNT_W(4)) u_dut3 (
        .clk(clk), .rst(rst3), .req_i(req3), .op_i(op_i), .addr_i(addr_i),
        .wdata_i(wdata_i), .stall_o(stall3), .valid_o(valid3), .rdata_o(rdata3),
        .misalign_o(mis3), .ram_ce_o(ce3), .ram_we_o(we3), .ram_addr_o(addr3),
        .ram_sel_o(sel3), .ram_data_o(data3), .ram_data_i(rin3)
    );

    // Byte-enabled RAM behind dut1; fixed word behind dut3
    assign rin1 = ram1[addr1[11:2]];
    assign rin3 = 32'h1234_5678;

    always @(posedge clk) begin
        if (ce1 && we1) begin
            for (int b = 0; b < 4; b++) begin
                if (sel1[b]) ram1[addr1[11:2]][b*8 +: 8] <= data1[b*8 +: 8];
            end
        end
    end

    // One dut1 transaction; entered and left #1 after a rising edge
    task automatic txn1(input logic [2:0] op, input logic [31:0] addr,
                        input logic [31:0] wdata, input int max_cyc);
        logic done;
        req1 = 1'b1; op_i = op; addr_i = addr; wdata_i = wdata;
        stall_map = '0; ce_map = '0; we_map = '0; valid_map = '0; mis_map = '0;
        seen_sel = '0; seen_addr = '0; seen_data = '0; res_rdata = 32'hXXXX_XXXX;
        for (int c = 0; c < max_cyc; c++) begin
            @(negedge clk);
            stall_map[c] = stall1; ce_map[c] = ce1; we_map[c] = we1;
            valid_map[c] = valid1; mis_map[c] = mis1;
            if (ce1) begin seen_sel = sel1; seen_addr = addr1; seen_data = data1; end
            if (valid1) res_rdata = rdata1;
            done = valid1 || (c == 0 && !stall1);
            @(posedge clk); #1;
            if (done) break;
        end
        req1 = 1'b0;
    endtask

    task automatic test_reset;
        rst1 = 1'b1; rst3 = 1'b1; req1 = 1'b0; req3 = 1'b0;
        op_i = 3'b000; addr_i = '0; wdata_i = '0;
        #2;
        n_total++;
        if ({stall1, valid1, mis1, ce1, we1} !== 5'b0) $display("FAIL reset_ctl1 got %b want 00000", {stall1, valid1, mis1, ce1, we1});
        else n_pass++;
        n_total++;
        if ({rdata1, addr1, sel1, data1} !== 100'b0) $display("FAIL reset_data1 rdata=%h addr=%h sel=%b data=%h want 0", rdata1, addr1, sel1, data1);
        else n_pass++;
        n_total++;
        if ({stall3, valid3, mis3, ce3, we3, rdata3} !== 37'b0) $display("FAIL reset_dut3 ctl=%b rdata=%h want 0", {stall3, valid3, mis3, ce3, we3}, rdata3);
        else n_pass++;
        repeat (2) @(posedge clk);
        @(negedge clk); rst1 = 1'b0; rst3 = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_sw;
        txn1(3'b111, 32'h0000_0100, 32'hDEAD_BEEF, 8);
        n_total++;
        if (stall_map !== 16'b0111) $display("FAIL sw_stall got %b want 0111", stall_map); else n_pass++;
        n_total++;
        if (ce_map !== 16'b0110 || we_map !== 16'b0110) $display("FAIL sw_ce_we ce=%b we=%b want 0110", ce_map, we_map); else n_pass++;
        n_total++;
        if (valid_map !== 16'b1000) $display("FAIL sw_valid got %b want 1000", valid_map); else n_pass++;
        n_total++;
        if (seen_sel !== 4'b1111 || seen_data !== 32'hDEAD_BEEF || seen_addr !== 32'h100) $display("FAIL sw_bus sel=%b data=%h addr=%h want 1111 deadbeef 100", seen_sel, seen_data, seen_addr); else n_pass++;
        n_total++;
        if (mis_map !== 16'b0) $display("FAIL sw_mis got %b want 0", mis_map); else n_pass++;
    endtask

    task automatic test_sb;
        txn1(3'b101, 32'h0000_0103, 32'h0000_00A5, 8);
        n_total++;
        if (seen_sel !== 4'b1000 || seen_data !== 32'hA5A5_A5A5 || seen_addr !== 32'h100) $display("FAIL sb_bus sel=%b data=%h addr=%h want 1000 a5a5a5a5 100", seen_sel, seen_data, seen_addr); else n_pass++;
        n_total++;
        if (valid_map !== 16'b1000) $display("FAIL sb_valid got %b want 1000", valid_map); else n_pass++;
        txn1(3'b100, 32'h0000_0100, 32'h0, 8);
        n_total++;
        if (res_rdata !== 32'hA5AD_BEEF) $display("FAIL lw_after_sb got %h want a5adbeef", res_rdata); else n_pass++;
        n_total++;
        if (ce_map !== 16'b0110 || we_map !== 16'b0 || seen_sel !== 4'b1111) $display("FAIL lw_bus ce=%b we=%b sel=%b want 0110 0 1111", ce_map, we_map, seen_sel); else n_pass++;
    endtask

    task automatic test_loads;
        txn1(3'b111, 32'h0000_0200, 32'h80FF_7F01, 8);
        n_total++;
        if (valid_map !== 16'b1000) $display("FAIL preload_valid got %b want 1000", valid_map); else n_pass++;
        txn1(3'b000, 32'h0000_0202, 32'h0, 8);
        n_total++;
        if (res_rdata !== 32'hFFFF_FFFF || seen_sel !== 4'b0100) $display("FAIL lb got %h sel=%b want ffffffff 0100", res_rdata, seen_sel); else n_pass++;
        txn1(3'b001, 32'h0000_0202, 32'h0, 8);
        n_total++;
        if (res_rdata !== 32'h0000_00FF) $display("FAIL lbu got %h want 000000ff", res_rdata); else n_pass++;
        txn1(3'b010, 32'h0000_0202, 32'h0, 8);
        n_total++;
        if (res_rdata !== 32'hFFFF_80FF || seen_sel !== 4'b1100) $display("FAIL lh got %h sel=%b want ffff80ff 1100", res_rdata, seen_sel); else n_pass++;
        txn1(3'b011, 32'h0000_0200, 32'h0, 8);
        n_total++;
        if (res_rdata !== 32'h0000_7F01 || seen_sel !== 4'b0011) $display("FAIL lhu got %h sel=%b want 00007f01 0011", res_rdata, seen_sel); else n_pass++;
        @(negedge clk);
        n_total++;
        if (rdata1 !== 32'h0000_7F01) $display("FAIL rdata_hold got %h want 00007f01", rdata1); else n_pass++;
        @(posedge clk); #1;
    endtask

    task automatic test_misalign;
        logic [2:0]  ops   [2] = '{3'b100, 3'b110};
        logic [31:0] addrs [2] = '{32'h0000_0101, 32'h0000_0203};
        for (int i = 0; i < 2; i++) begin
            txn1(ops[i], addrs[i], 32'h1111_2222, 4);
            n_total++;
            if (mis_map !== 16'b1 || stall_map !== 16'b0) $display("FAIL mis%0d_pulse mis=%b stall=%b want 1 0", i, mis_map, stall_map); else n_pass++;
            n_total++;
            if (ce_map !== 16'b0 || valid_map !== 16'b0) $display("FAIL mis%0d_noaccess ce=%b valid=%b want 0 0", i, ce_map, valid_map); else n_pass++;
            @(negedge clk);
            n_total++;
            if ({mis1, ce1, stall1, valid1} !== 4'b0) $display("FAIL mis%0d_after got %b want 0000", i, {mis1, ce1, stall1, valid1}); else n_pass++;
            @(posedge clk); #1;
        end
        // Still in IDLE: an aligned request completes with normal latency
        txn1(3'b100, 32'h0000_0200, 32'h0, 8);
        n_total++;
        if (valid_map !== 16'b1000 || res_rdata !== 32'h80FF_7F01) $display("FAIL mis_idle valid=%b rdata=%h want 1000 80ff7f01", valid_map, res_rdata); else n_pass++;
    endtask

    task automatic test_back_to_back;
        txn1(3'b100, 32'h0000_0100, 32'h0, 8);
        n_total++;
        if (valid_map !== 16'b1000 || res_rdata !== 32'hA5AD_BEEF) $display("FAIL b2b_first valid=%b rdata=%h want 1000 a5adbeef", valid_map, res_rdata); else n_pass++;
        txn1(3'b011, 32'h0000_0202, 32'h0, 8);
        n_total++;
        if (valid_map !== 16'b1000 || stall_map !== 16'b0111 || res_rdata !== 32'h0000_80FF) $display("FAIL b2b_second valid=%b stall=%b rdata=%h want 1000 0111 000080ff", valid_map, stall_map, res_rdata); else n_pass++;
    endtask

    task automatic test_wait3;
        logic [15:0] ce3_map, v3_map;
        logic [31:0] rd;
        logic        bad;
        ce3_map = '0; v3_map = '0; rd = 32'hXXXX_XXXX;
        req3 = 1'b1; op_i = 3'b100; addr_i = 32'h0000_0040; wdata_i = '0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            ce3_map[c] = ce3; v3_map[c] = valid3;
            if (valid3) rd = rdata3;
            @(posedge clk); #1;
            if (v3_map[c]) break;
        end
        req3 = 1'b0;
        n_total++;
        if (ce3_map !== 16'b1_1110) $display("FAIL w3_ce got %b want 11110", ce3_map); else n_pass++;
        n_total++;
        if (v3_map !== 16'b10_0000 || rd !== 32'h1234_5678) $display("FAIL w3_valid map=%b rdata=%h want 100000 12345678", v3_map, rd); else n_pass++;

        // Reset in cycle 2 of a second access
        op_i = 3'b010; addr_i = 32'h0000_0042;
        req3 = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        n_total++;
        if (ce3 !== 1'b1) $display("FAIL w3_pre_abort ce=%b want 1", ce3); else n_pass++;
        rst3 = 1'b1; req3 = 1'b0;
        #1;
        n_total++;
        if ({ce3, we3, stall3, valid3, mis3} !== 5'b0 || {addr3, sel3, data3} !== 68'b0) $display("FAIL w3_abort ctl=%b addr=%h sel=%b data=%h want 0", {ce3, we3, stall3, valid3, mis3}, addr3, sel3, data3); else n_pass++;
        @(negedge clk); rst3 = 1'b0;
        bad = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (valid3 || ce3) bad = 1'b1;
        end
        n_total++;
        if (bad !== 1'b0 || rdata3 !== 32'h0) $display("FAIL w3_no_valid seen=%b rdata=%h want 0 0", bad, rdata3); else n_pass++;
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_sw();
        test_sb();
        test_loads();
        test_misalign();
        test_back_to_back();
        test_wait3();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
